// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and constants for the exception/flush controller
package exc_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_ERET     = 3'd4
    } exc_state_t;

    // Next-PC select codes consumed by the fetch mux
    localparam logic [1:0] PCSEL_NORMAL  = 2'd0;
    localparam logic [1:0] PCSEL_HANDLER = 2'd1;
    localparam logic [1:0] PCSEL_EPC     = 2'd2;

    // Default exception handler entry address
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    // ExcCode values written into Cause
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Restart address of the faulting instruction: a delay-slot instruction
    // restarts at its branch, one word earlier (32-bit wrap).
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/drain_timer.sv
// rtl/drain_timer.sv - watchdog counter bounding the wait for the md unit
module drain_timer #(
    parameter logic [3:0] LIMIT = 4'd15
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + 4'd1;

    // Counts enabled cycles; clr wins so every drain starts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if (clr) begin
            r_cnt <= 4'd0;
        end else if (en) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Fires during the LIMIT-th enabled cycle so the drain lasts LIMIT cycles
    assign expired = en && (w_cnt_nxt == LIMIT);

endmodule

// File: rtl/exc_flush_ctrl.sv
// rtl/exc_flush_ctrl.sv - pipeline exception, interrupt and eret sequencing
module exc_flush_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [3:0]  DRAIN_MAX  = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        int_req,
    input  logic        eret_m,
    input  logic        md_busy,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [31:0] epc_q,
    output logic        stall,
    output logic        clr_fd,
    output logic        clr_de,
    output logic        clr_em,
    output logic        clr_mw,
    output logic [1:0]  pc_sel,
    output logic        epc_wr,
    output logic [31:0] epc_out,
    output logic        cause_wr,
    output logic [4:0]  cause_code,
    output logic        exl
);

    exc_state_t  r_state;
    exc_state_t  w_state_nxt;
    logic [31:0] r_epc;
    logic [4:0]  r_code;
    logic        r_exl;

    logic        w_take_int;
    logic        w_take_exc;
    logic        w_take_trap;
    logic        w_expired;
    logic        w_in_drain;

    // The fetch mux applies the handler address and epc_q from pc_sel;
    // they pass through here only so the parameter lives with its sequencer.
    logic [31:0] w_unused_handler_pc;
    logic [31:0] w_unused_epc_q;
    assign w_unused_handler_pc = HANDLER_PC;
    assign w_unused_epc_q      = epc_q;

    // Interrupts are masked while already at exception level
    assign w_take_int  = int_req && !r_exl;
    assign w_take_exc  = !w_take_int && exc_req;
    assign w_take_trap = w_take_int || w_take_exc;
    assign w_in_drain  = (r_state == ST_DRAIN);

    drain_timer #(
        .LIMIT   (DRAIN_MAX)
    ) u_drain_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (w_in_drain),
        .clr     (!w_in_drain),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; requests are only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take_trap) begin
                    w_state_nxt = md_busy ? ST_DRAIN : ST_FLUSH;
                end else if (eret_m) begin
                    w_state_nxt = ST_ERET;
                end
            end
            ST_DRAIN: begin
                if (!md_busy || w_expired) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH:    w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: w_state_nxt = ST_IDLE;
            ST_ERET:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture code and restart address of the accepted trap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc  <= 32'd0;
            r_code <= 5'd0;
        end else if ((r_state == ST_IDLE) && w_take_trap) begin
            r_epc  <= epc_of(pc_m, bd_m);
            r_code <= w_take_int ? EXC_INT : exc_code;
        end
    end

    // Exception level: raised as the flush completes, dropped by eret
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exl <= 1'b0;
        end else if (r_state == ST_FLUSH) begin
            r_exl <= 1'b1;
        end else if (r_state == ST_ERET) begin
            r_exl <= 1'b0;
        end
    end

    // Moore output decode
    always_comb begin
        stall    = 1'b0;
        clr_fd   = 1'b0;
        clr_de   = 1'b0;
        clr_em   = 1'b0;
        clr_mw   = 1'b0;
        pc_sel   = PCSEL_NORMAL;
        epc_wr   = 1'b0;
        cause_wr = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                stall = 1'b1;
            end
            ST_FLUSH: begin
                clr_fd   = 1'b1;
                clr_de   = 1'b1;
                clr_em   = 1'b1;
                clr_mw   = 1'b1;
                cause_wr = 1'b1;
                // A nested trap keeps the original restart address
                epc_wr   = !r_exl;
            end
            ST_REDIRECT: begin
                pc_sel = PCSEL_HANDLER;
            end
            ST_ERET: begin
                // The eret itself retires through W, so M/W is kept
                clr_fd = 1'b1;
                clr_de = 1'b1;
                clr_em = 1'b1;
                pc_sel = PCSEL_EPC;
            end
            default: ;
        endcase
    end

    assign epc_out    = r_epc;
    assign cause_code = r_code;
    assign exl        = r_exl;

endmodule
